// File: rtl/seq_det_pkg.sv
// Shared types and constants for the sequence-detector scheduler.
// The detector pattern is also used by the bench's detector model.
package seq_det_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_SHIFT,
        ST_DRAIN,
        ST_RESP
    } state_e;

    localparam int DET_LEN = 12;
    localparam logic [DET_LEN-1:0] DET_PATTERN = 12'b1110_1101_1011;

endpackage

// File: rtl/seq_det_sched_arb.sv
// Round-robin arbiter: one-hot grant to the lowest requesting index >= ptr,
// wrapping to index 0 when nothing at or above ptr is requesting.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] grant_o
);

    logic found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        // First pass honours the pointer, second pass handles the wrap.
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && en_i && req_i[j] && (j >= int'(ptr_i))) begin
                grant_o[j] = 1'b1;
                found      = 1'b1;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && en_i && req_i[j]) begin
                grant_o[j] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_det_sched.sv
// Shares one serial 12-bit sequence detector among NUM_REQ requesters:
// grant, clear detector, shift word LSB-first, count hits, return tagged response.
module seq_det_sched
    import seq_det_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WORD_W  = 16,
    parameter int DET_LAT = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*WORD_W-1:0]     req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          det_rst_o,
    output logic                          det_x_o,
    input  logic                          det_i,
    output logic                          rsp_valid_o,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id_o,
    output logic                          rsp_hit_o,
    output logic [$clog2(WORD_W+1)-1:0]   rsp_cnt_o,
    input  logic                          rsp_ready_i
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam int WIN_W = $clog2(WORD_W + DET_LAT + 1);
    localparam logic [WIN_W-1:0] LAST_BIT = WIN_W'(WORD_W - 1);
    localparam logic [WIN_W-1:0] LAST_WIN = WIN_W'(WORD_W + DET_LAT - 1);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d, id_q, id_d, gnt_id;
    logic [WORD_W-1:0]   word_q, word_d, gnt_word;
    logic [WIN_W-1:0]    win_q, win_d;
    logic [CNT_W-1:0]    hit_q, hit_d;
    logic [NUM_REQ-1:0]  grant;
    logic                arb_en, win_ok, sample;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .en_i    (arb_en),
        .grant_o (grant)
    );

    assign req_ready_o = grant;

    always_comb begin
        gnt_id   = '0;
        gnt_word = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                gnt_id   = ID_W'(k);
                gnt_word = req_data_i[k*WORD_W +: WORD_W];
            end
        end
    end

    // The first DET_LAT window slots carry detector output from before the word.
    generate
        if (DET_LAT == 0) begin : g_nolat
            assign win_ok = 1'b1;
        end else begin : g_lat
            assign win_ok = (win_q >= WIN_W'(DET_LAT));
        end
    endgenerate

    assign sample = win_ok & det_i;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        word_d      = word_q;
        win_d       = win_q;
        hit_d       = hit_q;
        arb_en      = 1'b0;
        det_rst_o   = reset;
        det_x_o     = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_id_o    = '0;
        rsp_hit_o   = 1'b0;
        rsp_cnt_o   = '0;
        case (state_q)
            ST_IDLE: begin
                arb_en = ~reset;
                if (|grant) begin
                    word_d  = gnt_word;
                    id_d    = gnt_id;
                    ptr_d   = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
                    state_d = ST_CLR;
                end
            end
            ST_CLR: begin
                det_rst_o = 1'b1;
                win_d     = '0;
                hit_d     = '0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                det_x_o = word_q[0];
                word_d  = word_q >> 1;
                win_d   = win_q + WIN_W'(1);
                if (sample) hit_d = hit_q + CNT_W'(1);
                if (win_q == LAST_BIT) state_d = (DET_LAT > 0) ? ST_DRAIN : ST_RESP;
            end
            ST_DRAIN: begin
                win_d = win_q + WIN_W'(1);
                if (sample) hit_d = hit_q + CNT_W'(1);
                if (win_q == LAST_WIN) state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                rsp_id_o    = id_q;
                rsp_hit_o   = (hit_q != '0);
                rsp_cnt_o   = hit_q;
                if (rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            word_q  <= '0;
            win_q   <= '0;
            hit_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            word_q  <= word_d;
            win_q   <= win_d;
            hit_q   <= hit_d;
        end
    end

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: three instances (DET_LAT 0/1/2), each with its own
// detector model; expectations queued at grant time, checked by per-instance monitors.
module tb_seq_det_sched;
    import seq_det_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int WORD_W  = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rsp_ready = 1'b1;
    logic [NUM_REQ*WORD_W-1:0] data = '0;
    logic [NUM_REQ-1:0] valid [3];
    logic [NUM_REQ-1:0] ready [3];
    logic det_rst [3];
    logic det_x [3];
    logic det [3];
    logic rsp_valid [3];
    logic rsp_hit [3];
    logic [0:0] rsp_id [3];
    logic [4:0] rsp_cnt [3];

    int hold_len [3];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int inst;
        int id;
        int cnt;
        int gcyc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    for (genvar L = 0; L < 3; L++) begin : g
        seq_det_sched #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W), .DET_LAT(L)) dut (
            .clk         (clk),
            .reset       (reset),
            .req_valid_i (valid[L]),
            .req_data_i  (data),
            .req_ready_o (ready[L]),
            .det_rst_o   (det_rst[L]),
            .det_x_o     (det_x[L]),
            .det_i       (det[L]),
            .rsp_valid_o (rsp_valid[L]),
            .rsp_id_o    (rsp_id[L]),
            .rsp_hit_o   (rsp_hit[L]),
            .rsp_cnt_o   (rsp_cnt[L]),
            .rsp_ready_i (rsp_ready)
        );

        // Detector model: newest bit enters at the MSB, so an LSB-first word
        // lines up with the pattern's bit order; output delayed by L cycles.
        logic [DET_LEN-1:0] sr = '0;
        logic [2:0] dpipe = '0;
        logic match;
        assign match = ({det_x[L], sr[DET_LEN-1:1]} == DET_PATTERN);
        always @(posedge clk) begin
            if (det_rst[L]) begin
                sr    <= '0;
                dpipe <= '0;
            end else begin
                sr    <= {det_x[L], sr[DET_LEN-1:1]};
                dpipe <= {dpipe[1:0], match};
            end
        end
        if (L == 0) begin : g0
            assign det[L] = match;
        end else begin : gn
            assign det[L] = dpipe[L-1];
        end

        int run = 0;
        int first = 0;
        int idx;
        initial begin
            forever begin
                @(negedge clk);
                if (rsp_valid[L]) begin
                    if (run == 0) first = cyc;
                    run++;
                    idx = -1;
                    for (int i = 0; i < sb.size(); i++)
                        if (idx < 0 && sb[i].inst == L) idx = i;
                    if (idx < 0) begin
                        chk($sformatf("unexpected_rsp[%0d]", L), 1, 0);
                        if (rsp_ready) run = 0;
                    end else begin
                        chk($sformatf("rsp_id[%0d]", L), int'(rsp_id[L]), sb[idx].id);
                        chk($sformatf("rsp_cnt[%0d]", L), int'(rsp_cnt[L]), sb[idx].cnt);
                        chk($sformatf("rsp_hit[%0d]", L), int'(rsp_hit[L]), int'(sb[idx].cnt != 0));
                        if (rsp_ready) begin
                            chk($sformatf("latency[%0d]", L), first - sb[idx].gcyc, 18 + L);
                            hold_len[L] = run;
                            sb.delete(idx);
                            run = 0;
                        end
                    end
                end else begin
                    run = 0;
                end
            end
        end
    end

    task automatic set_valid(input int L, input logic [1:0] v);
        @(posedge clk); #1;
        valid[L] = v;
    endtask

    // Raise requests, wait for the grant, queue the expected response.
    task automatic job(input int L, input logic [1:0] vmask, input logic [1:0] exp_rdy,
                       input int exp_id, input int exp_cnt);
        int t;
        bit got;
        @(posedge clk); #1;
        valid[L] = vmask;
        got = 1'b0;
        t = 0;
        while (!got && t < 100) begin
            @(negedge clk);
            t++;
            if (ready[L] != '0) got = 1'b1;
        end
        if (!got) begin
            chk($sformatf("grant_timeout[%0d]", L), 0, 1);
        end else begin
            chk($sformatf("grant[%0d]", L), int'(ready[L]), int'(exp_rdy));
            sb.push_back('{L, exp_id, exp_cnt, cyc});
            @(negedge clk);
            chk($sformatf("ready_pulse[%0d]", L), int'(ready[L]), 0);
            chk($sformatf("clr_det_rst[%0d]", L), int'(det_rst[L]), 1);
            @(negedge clk);
            chk($sformatf("clr_end[%0d]", L), int'(det_rst[L]), 0);
        end
    endtask

    task automatic wait_done(input int L, output int saw_x);
        int t;
        bit busy;
        saw_x = 0;
        busy = 1'b1;
        t = 0;
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
            if (det_x[L]) saw_x = 1;
            busy = 1'b0;
            foreach (sb[i]) if (sb[i].inst == L) busy = 1'b1;
        end
        if (busy) chk($sformatf("done_timeout[%0d]", L), 0, 1);
    endtask

    initial begin
        int sx;
        int t;
        for (int i = 0; i < 3; i++) valid[i] = '0;
        for (int i = 0; i < 3; i++) hold_len[i] = 0;
        valid[1] = 2'b11;
        repeat (2) @(negedge clk);
        chk("rst_det_rst", int'(det_rst[1]), 1);
        chk("rst_ready", int'(ready[1]), 0);
        chk("rst_rsp_valid", int'(rsp_valid[1]), 0);
        chk("rst_det_x", int'(det_x[1]), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        valid[1] = 2'b00;
        @(negedge clk);
        chk("idle_det_rst", int'(det_rst[1]), 0);

        // single job, pattern in bits 0..11
        data[15:0] = 16'h0EDB;
        job(1, 2'b01, 2'b01, 0, 1);
        set_valid(1, 2'b00);
        wait_done(1, sx);

        // all-zero word: no hits, serial line never high
        data[31:16] = 16'h0000;
        job(1, 2'b10, 2'b10, 1, 0);
        set_valid(1, 2'b00);
        wait_done(1, sx);
        chk("no_match_det_x", sx, 0);

        // fairness with both requesters continuously valid
        data = {16'h0EDB, 16'h0EDB};
        job(1, 2'b11, 2'b01, 0, 1);
        job(1, 2'b11, 2'b10, 1, 1);
        job(1, 2'b11, 2'b01, 0, 1);
        job(1, 2'b11, 2'b10, 1, 1);
        set_valid(1, 2'b00);
        wait_done(1, sx);

        // response backpressure: ready low for 5 response cycles
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        job(1, 2'b11, 2'b01, 0, 1);
        t = 0;
        while (!rsp_valid[1] && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("bp_rsp_seen", int'(rsp_valid[1]), 1);
        chk("bp_no_grant", int'(ready[1]), 0);
        repeat (4) begin
            @(negedge clk);
            chk("bp_no_grant", int'(ready[1]), 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        job(1, 2'b11, 2'b10, 1, 1);
        chk("bp_hold_len", hold_len[1], 6);
        set_valid(1, 2'b00);
        wait_done(1, sx);

        // reset during SHIFT bit 7 of a job from requester 0
        job(1, 2'b01, 2'b01, 0, 1);
        repeat (7) @(posedge clk);
        #1;
        chk("pre_rst_busy", int'(rsp_valid[1]), 0);
        reset = 1'b1;
        valid[1] = 2'b11;
        #1;
        chk("mid_rst_det_rst", int'(det_rst[1]), 1);
        chk("mid_rst_det_x", int'(det_x[1]), 0);
        chk("mid_rst_ready", int'(ready[1]), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        valid[1] = 2'b00;
        job(1, 2'b11, 2'b01, 0, 1);
        set_valid(1, 2'b00);
        wait_done(1, sx);

        // pointer wrap; pattern ending on the last bit; no-hit words
        data[15:0] = 16'hEDB0;
        job(1, 2'b01, 2'b01, 0, 1);
        set_valid(1, 2'b00);
        wait_done(1, sx);
        data[31:16] = 16'hFFFF;
        job(1, 2'b10, 2'b10, 1, 0);
        set_valid(1, 2'b00);
        wait_done(1, sx);
        data[15:0] = 16'h0EDA;
        job(1, 2'b01, 2'b01, 0, 0);
        set_valid(1, 2'b00);
        wait_done(1, sx);

        // detector latency 0 and 2
        data[15:0] = 16'h0EDB;
        job(0, 2'b01, 2'b01, 0, 1);
        set_valid(0, 2'b00);
        job(2, 2'b01, 2'b01, 0, 1);
        set_valid(2, 2'b00);
        wait_done(0, sx);
        wait_done(2, sx);
        data[15:0] = 16'hEDB0;
        job(0, 2'b01, 2'b01, 0, 1);
        set_valid(0, 2'b00);
        job(2, 2'b01, 2'b01, 0, 1);
        set_valid(2, 2'b00);
        wait_done(0, sx);
        wait_done(2, sx);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
